// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM encoding,
// common keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // PS/2 frames use odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
// Flops reset to 1 so an idle (released, pulled-up) line never looks like a fall.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchronizer chain and the edge-history flop.
  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// shifts one byte out LSB first with odd parity and stop bit on the
// device-generated clock, then checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 1200,
  parameter int START_TIMEOUT_CYCLES = 150000,
  parameter int BIT_TIMEOUT_CYCLES   = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                   : START_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_END    = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT_CYCLES - 1);

  logic clk_level, clk_fall;
  logic data_level, unused_data_fall;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_in (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_in (ps2_data_in),
    .level  (data_level),
    .fall   (unused_data_fall)
  );

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ack_ok_q, ack_ok_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             expire;

  // Next-state and registered-output logic; a device fall beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    expire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = odd_parity(tx_data);
          cnt_d    = '0;
          idx_d    = '0;
          ack_ok_d = 1'b0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        // Start bit goes low one cycle before the clock line is let go.
        if (cnt_q == INH_END) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = REQ;
        end else begin
          if (cnt_q == INH_LAST) data_oe_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REQ: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          idx_d     = 4'd1;
          cnt_d     = '0;
          state_d   = DATA;
        end else if (cnt_q == START_LAST) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA, PARITY, ACK: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (state_q == DATA) begin
            if (idx_q == 4'd8) begin
              data_oe_d = ~parity_q;
              state_d   = PARITY;
            end else begin
              data_oe_d = ~shift_q[idx_q[2:0]];
              idx_d     = idx_q + 4'd1;
            end
          end else if (state_q == PARITY) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            ack_ok_d = ~data_level;
            state_d  = WAIT_IDLE;
          end
        end else if (cnt_q == BIT_LAST) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (clk_level && data_level) begin
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (expire) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
      busy_d    = 1'b0;
      cnt_d     = '0;
      idx_d     = '0;
      state_d   = IDLE;
    end
  end

  // State, datapath and output registers; reset releases both lines at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock,
// samples the host's frame on rising edges and answers with or without ACK.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH    = 20;
  localparam int START  = 300;
  localparam int BIT_TO = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_error;
  logic       dev_clk_low, dev_data_low;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  // Open-collector bus: low if either side pulls.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (START),
    .BIT_TIMEOUT_CYCLES   (BIT_TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line levels: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = (((b >> i) % 2) != 0);
      ones += int'((b >> i) % 2);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Result pulse monitor.
  always @(negedge clock) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
    if (tx_done || tx_error) begin
      check_eq("pulse_exclusive", tx_done & tx_error, 0);
      check_eq("busy_low_on_pulse", busy, 0);
    end
  end

  // One host transfer against the device model.
  // nfalls: 11 = full frame, 0 = device never clocks, else device stalls after that fall.
  task automatic xfer(input logic [7:0] b, input bit ack, input int nfalls,
                      input int half, input bit kick, input string tag);
    logic [10:0] exp_f, got_f;
    logic        prev_doe, last_doe;
    int          n, base_done, base_err, last_idx;
    bit          expect_done;
    exp_f = frame_of(b);
    got_f = '0;
    base_done = done_cnt;
    base_err  = err_cnt;
    expect_done = ack && (nfalls == 11);

    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);

    n = 0; prev_doe = 1'b0; last_doe = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < INH + 20) begin
      prev_doe = last_doe;
      last_doe = ps2_data_oe;
      n++;
      @(negedge clock);
    end
    check_eq({tag, "_inhibit_len"}, n, INH + 1);
    check_eq({tag, "_start_last_inh"}, last_doe, 1);
    check_eq({tag, "_start_prev_inh"}, prev_doe, 0);
    check_eq({tag, "_req_data_oe"}, ps2_data_oe, 1);

    if (nfalls == 0) begin
      n = 0;
      while (tx_error !== 1'b1 && n < START + 20) begin
        @(negedge clock);
        n++;
      end
      check_eq({tag, "_start_timeout"}, n, START);
      check_eq({tag, "_to_clk_oe"}, ps2_clk_oe, 0);
      check_eq({tag, "_to_data_oe"}, ps2_data_oe, 0);
    end else begin
      repeat (3) @(negedge clock);
      got_f[0] = ps2_data_in;
      for (int k = 1; k <= nfalls; k++) begin
        dev_clk_low = 1'b1;
        if (k == nfalls && nfalls < 11) begin
          n = 0;
          while (tx_error !== 1'b1 && n < BIT_TO + 20) begin
            @(negedge clock);
            n++;
            if (n == half) dev_clk_low = 1'b0;
          end
          dev_clk_low = 1'b0;
          check_eq({tag, "_bit_timeout"}, n, BIT_TO + 3);
          check_eq({tag, "_bto_clk_oe"}, ps2_clk_oe, 0);
          check_eq({tag, "_bto_data_oe"}, ps2_data_oe, 0);
          break;
        end
        repeat (half) @(negedge clock);
        if (k <= 10) got_f[k] = ps2_data_in;
        dev_clk_low = 1'b0;
        for (int j = 0; j < half; j++) begin
          if (kick && k == 2 && j == 0) begin
            tx_data  = ~b;
            tx_start = 1'b1;
          end
          if (ack && k == 10 && j == 1) dev_data_low = 1'b1;
          @(negedge clock);
          if (kick && k == 2 && j == 0) begin
            tx_start = 1'b0;
            tx_data  = b;
            check_eq({tag, "_busy_after_kick"}, busy, 1);
          end
        end
      end
      dev_data_low = 1'b0;
      last_idx = (nfalls == 11) ? 10 : nfalls - 1;
      for (int i = 0; i <= last_idx; i++)
        check_eq($sformatf("%s_line_bit%0d", tag, i), got_f[i], exp_f[i]);
    end

    n = 0;
    while ((done_cnt + err_cnt) == (base_done + base_err) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_pulse_seen"}, ((done_cnt + err_cnt) != (base_done + base_err)), 1);
    repeat (4) @(negedge clock);
    check_eq({tag, "_done_count"}, done_cnt - base_done, expect_done ? 1 : 0);
    check_eq({tag, "_error_count"}, err_cnt - base_err, expect_done ? 0 : 1);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_clk_oe_after"}, ps2_clk_oe, 0);
    check_eq({tag, "_data_oe_after"}, ps2_data_oe, 0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    tx_data      = 8'h00;
    tx_start     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clk_oe", ps2_clk_oe, 0);
    check_eq("rst_data_oe", ps2_data_oe, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_error", tx_error, 0);

    xfer(PS2_CMD_SET_LEDS, 1'b1, 11, 8, 1'b0, "leds");
    xfer(8'h00,            1'b1, 11, 7, 1'b0, "zero");
    xfer(PS2_CMD_RESET,    1'b0, 11, 8, 1'b0, "nack");
    xfer(8'h3C,            1'b1,  0, 8, 1'b0, "nostart");
    xfer(8'hA3,            1'b1,  4, 8, 1'b0, "stall");
    xfer(PS2_CMD_ENABLE,   1'b1, 11, 8, 1'b0, "enable");

    // Reset in the middle of the data bits.
    @(negedge clock);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < INH + 20) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (8) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (8) @(negedge clock);
    end
    check_eq("rstmid_pre_data_oe", ps2_data_oe, 1);
    check_eq("rstmid_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rstmid_clk_oe", ps2_clk_oe, 0);
    check_eq("rstmid_data_oe", ps2_data_oe, 0);
    check_eq("rstmid_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rstmid_idle_busy", busy, 0);
    check_eq("rstmid_idle_data_oe", ps2_data_oe, 0);

    xfer(8'h5A, 1'b1, 11, 8, 1'b1, "kick");

    for (int t = 0; t < 6; t++) begin
      logic [7:0] rb;
      bit         rack;
      int         rhalf;
      rb    = 8'($urandom);
      rack  = 1'($urandom % 2);
      rhalf = int'($urandom_range(5, 10));
      xfer(rb, rack, 11, rhalf, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
